// File: rtl/fetch_pc_unit_pkg.sv
// Shared encodings for the fetch front end: next-PC select codes, FSM states
// and the instruction word presented before the first fetch completes.
package fetch_pc_unit_pkg;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_REQ,
        FS_WAIT,
        FS_EXEC,
        FS_HALT
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit_npc_calc.sv
// Combinational next-PC selection; flags targets that are not word aligned.
module fetch_pc_unit_npc_calc
    import fetch_pc_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [2:0]  npc_op,
    input  logic [31:0] imm,
    input  logic [31:0] alu_out,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    always_comb begin
        next_pc = pc + 32'd4;
        case (npc_op)
            NPC_BRANCH,
            NPC_JUMP:   next_pc = pc + imm;
            // JALR clears bit 0 of rs1+imm; bit 1 can still leave it misaligned.
            NPC_JALR:   next_pc = alu_out & 32'hFFFF_FFFE;
            default:    next_pc = pc + 32'd4;
        endcase
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: PC register, req/gnt/rvalid IMEM handshake,
// instruction hold for decode, retire counter and sticky fault halt.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [2:0]  npc_op,
    input  logic [31:0] imm,
    input  logic [31:0] alu_out,
    input  logic        exec_done,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        halted,
    output logic [31:0] instret
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instret_q, instret_d;
    logic         req_q, vld_q, halt_q;
    logic [31:0]  next_pc;
    logic         misaligned;

    fetch_pc_unit_npc_calc u_npc_calc (
        .pc         (pc_q),
        .npc_op     (npc_op),
        .imm        (imm),
        .alu_out    (alu_out),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        instret_d = instret_q;
        case (state_q)
            FS_IDLE: state_d = FS_REQ;
            FS_REQ: begin
                if (imem_gnt) state_d = FS_WAIT;
            end
            FS_WAIT: begin
                if (imem_rvalid) begin
                    if (imem_err) begin
                        state_d = FS_HALT;
                    end else begin
                        instr_d = imem_rdata;
                        state_d = FS_EXEC;
                    end
                end
            end
            FS_EXEC: begin
                if (exec_done) begin
                    // A misaligned target faults without committing the PC or count.
                    if (misaligned) begin
                        state_d = FS_HALT;
                    end else begin
                        pc_d      = next_pc;
                        instret_d = instret_q + 32'd1;
                        state_d   = FS_REQ;
                    end
                end
            end
            FS_HALT: state_d = FS_HALT;
            default: state_d = FS_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they align with state_q.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= FS_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            instret_q <= 32'd0;
            req_q     <= 1'b0;
            vld_q     <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            instret_q <= instret_d;
            req_q     <= (state_d == FS_REQ);
            vld_q     <= (state_d == FS_EXEC);
            halt_q    <= (state_d == FS_HALT);
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign instr       = instr_q;
    assign instr_valid = vld_q;
    assign halted      = halt_q;
    assign instret     = instret_q;

endmodule
